// File: rtl/fp32_mul_seq.sv
// Sequential FP32 multiplier: 24-cycle shift-add mantissa product, then normalize and round.
// Denormals flush to zero; special operands bypass the arithmetic but keep the same latency.
module fp32_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic [1:0]  rmode_i,
    output logic        ready_o,
    output logic [31:0] output_o,
    output logic        ine_o,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic        inf_o,
    output logic        zero_o,
    output logic        qnan_o,
    output logic        snan_o
);

    localparam int unsigned MUL_CYCLES = 24;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StMul   = 3'd1;
    localparam logic [2:0] StNorm  = 3'd2;
    localparam logic [2:0] StRound = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [4:0]  cnt_q;
    logic        accept;

    logic [31:0] opa_q, opb_q;
    logic [1:0]  rmode_q;

    logic [47:0] acc_q, mcand_q;
    logic [23:0] mplier_q;

    logic [23:0]        mant_q, mant_n;
    logic               guard_q, guard_n;
    logic               sticky_q, sticky_n;
    logic signed [9:0]  exp_q, exp_n;

    logic               sign;
    logic               inc;
    logic [24:0]        mant_sum;
    logic [22:0]        mant_r;
    logic signed [9:0]  exp_r;
    logic               ovf_to_inf;

    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        any_snan, any_qnan, inv_op;

    logic [31:0] res_d;
    logic        ine_d, overflow_d, underflow_d, inf_d, zero_d, qnan_d, snan_d;

    // Zero exponent (zero or denormal) contributes a zero significand.
    function automatic logic [23:0] sig_of(input logic [31:0] x);
        sig_of = (x[30:23] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
    endfunction

    assign accept  = start_i && ((state_q == StIdle) || (state_q == StDone));
    assign ready_o = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_i) state_d = StMul;
            StMul:   if (cnt_q == 5'(MUL_CYCLES - 1)) state_d = StNorm;
            StNorm:  state_d = StRound;
            StRound: state_d = StDone;
            StDone:  state_d = start_i ? StMul : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Operand classification from the captured operands.
    always_comb begin
        sign     = opa_q[31] ^ opb_q[31];
        a_zero   = (opa_q[30:23] == 8'd0);
        b_zero   = (opb_q[30:23] == 8'd0);
        a_inf    = (opa_q[30:23] == 8'hFF) && (opa_q[22:0] == 23'd0);
        b_inf    = (opb_q[30:23] == 8'hFF) && (opb_q[22:0] == 23'd0);
        a_nan    = (opa_q[30:23] == 8'hFF) && (opa_q[22:0] != 23'd0);
        b_nan    = (opb_q[30:23] == 8'hFF) && (opb_q[22:0] != 23'd0);
        any_snan = (a_nan && !opa_q[22]) || (b_nan && !opb_q[22]);
        any_qnan = (a_nan && opa_q[22]) || (b_nan && opb_q[22]);
        inv_op   = (a_inf && b_zero) || (b_inf && a_zero);
    end

    // Normalization of the 48-bit product.
    always_comb begin
        exp_n = $signed({2'b00, opa_q[30:23]}) + $signed({2'b00, opb_q[30:23]}) - 10'sd127
              + (acc_q[47] ? 10'sd1 : 10'sd0);
        if (acc_q[47]) begin
            mant_n   = acc_q[47:24];
            guard_n  = acc_q[23];
            sticky_n = |acc_q[22:0];
        end else begin
            mant_n   = acc_q[46:23];
            guard_n  = acc_q[22];
            sticky_n = |acc_q[21:0];
        end
    end

    // Rounding increment and mantissa carry-out.
    always_comb begin
        inc = 1'b0;
        case (rmode_q)
            2'd0:    inc = guard_q & (sticky_q | mant_q[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = (guard_q | sticky_q) & ~sign;
            default: inc = (guard_q | sticky_q) & sign;
        endcase
        mant_sum   = {1'b0, mant_q} + {24'd0, inc};
        mant_r     = mant_sum[24] ? mant_sum[23:1] : mant_sum[22:0];
        exp_r      = exp_q + (mant_sum[24] ? 10'sd1 : 10'sd0);
        ovf_to_inf = (rmode_q == 2'd0) || ((rmode_q == 2'd2) && !sign)
                   || ((rmode_q == 2'd3) && sign);
    end

    // Final result selection; NaN cases take priority over inf and zero.
    always_comb begin
        res_d       = 32'd0;
        ine_d       = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        inf_d       = 1'b0;
        zero_d      = 1'b0;
        qnan_d      = 1'b0;
        snan_d      = 1'b0;
        if (any_snan || any_qnan || inv_op) begin
            res_d  = 32'h7FC0_0000;
            snan_d = any_snan;
            qnan_d = any_qnan || inv_op;
        end else if (a_inf || b_inf) begin
            res_d = {sign, 8'hFF, 23'd0};
            inf_d = 1'b1;
        end else if (a_zero || b_zero) begin
            res_d  = {sign, 31'd0};
            zero_d = 1'b1;
        end else if (exp_r >= 10'sd255) begin
            overflow_d = 1'b1;
            ine_d      = 1'b1;
            if (ovf_to_inf) begin
                res_d = {sign, 8'hFF, 23'd0};
                inf_d = 1'b1;
            end else begin
                res_d = {sign, 31'h7F7F_FFFF};
            end
        end else if (exp_r <= 10'sd0) begin
            res_d       = {sign, 31'd0};
            underflow_d = 1'b1;
            ine_d       = 1'b1;
            zero_d      = 1'b1;
        end else begin
            res_d = {sign, exp_r[7:0], mant_r};
            ine_d = guard_q | sticky_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 5'd0;
            opa_q       <= 32'd0;
            opb_q       <= 32'd0;
            rmode_q     <= 2'd0;
            acc_q       <= 48'd0;
            mcand_q     <= 48'd0;
            mplier_q    <= 24'd0;
            mant_q      <= 24'd0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            exp_q       <= 10'sd0;
            output_o    <= 32'd0;
            ine_o       <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            inf_o       <= 1'b0;
            zero_o      <= 1'b0;
            qnan_o      <= 1'b0;
            snan_o      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                opa_q    <= opa_i;
                opb_q    <= opb_i;
                rmode_q  <= rmode_i;
                acc_q    <= 48'd0;
                mcand_q  <= {24'd0, sig_of(opa_i)};
                mplier_q <= sig_of(opb_i);
                cnt_q    <= 5'd0;
            end else if (state_q == StMul) begin
                if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                mcand_q  <= {mcand_q[46:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[23:1]};
                cnt_q    <= cnt_q + 5'd1;
            end
            if (state_q == StNorm) begin
                mant_q   <= mant_n;
                guard_q  <= guard_n;
                sticky_q <= sticky_n;
                exp_q    <= exp_n;
            end
            if (state_q == StRound) begin
                output_o    <= res_d;
                ine_o       <= ine_d;
                overflow_o  <= overflow_d;
                underflow_o <= underflow_d;
                inf_o       <= inf_d;
                zero_o      <= zero_d;
                qnan_o      <= qnan_d;
                snan_o      <= snan_d;
            end
        end
    end

endmodule

// File: doc/fp32_mul_seq.md
# fp32_mul_seq

Multi-cycle single-precision IEEE-754 multiplier that answers the FPU start/ready request protocol. The issuing side pulses `start_i` with operands and a rounding mode; this block multiplies mantissas with an iterative shift-add datapath, then normalizes and rounds. It pulses `ready_o` with the result and exception flags. It sits behind the FPU issue logic as a low-area responder for `fpu_op` multiply requests.

## Interface
- `MUL_CYCLES`, 24: shift-add iterations. Fixed to the mantissa width and not user-tunable.
- `clk` input 1: clock. Reset `rst`, asynchronous, active-high; clock `clk`.
- `rst` input 1: asynchronous active-high reset.
- `start_i` input 1: request pulse. Sampled only when the block is idle.
- `opa_i` input 32: operand A, FP32.
- `opb_i` input 32: operand B, FP32.
- `rmode_i` input 2: rounding mode. 0 = nearest-even, 1 = toward zero, 2 = toward +inf, 3 = toward -inf.
- `ready_o` output 1: one-cycle pulse; result and flags are valid from this cycle.
- `output_o` output 32: product.
- `ine_o`, `overflow_o`, `underflow_o`, `inf_o`, `zero_o`, `qnan_o`, `snan_o` output 1 each: exception and class flags.

## Operation
- **States:**
  - IDLE: waits for `start_i`.
  - MUL: 24 cycles.
  - NORM: 1 cycle.
  - ROUND: 1 cycle.
  - DONE: 1 cycle, `ready_o`=1.
  - DONE then returns to IDLE.
- **Accepting a request:** `start_i` is accepted in IDLE or DONE. On acceptance, `opa_i`, `opb_i` and `rmode_i` are captured. `start_i` in MUL, NORM or ROUND is ignored; nothing is queued.
- **Unpack:**
  - Exponent 0 means zero. Denormal inputs are flushed to signed zero.
  - Exponent 255 with zero mantissa is inf.
  - Exponent 255 with nonzero mantissa is NaN: quiet if bit 22 = 1, signaling otherwise.
  - Sign of the result = sign A xor sign B.
- **MUL:** 48-bit accumulator. Each cycle, test one multiplier bit (LSB first) of B's 24-bit significand (hidden 1 included), add A's shifted significand when the bit is set, and shift.
- **NORM:**
  - Exponent is computed in 10-bit signed: eA + eB - 127.
  - If product bit 47 = 1, keep bits 47:24 and add 1 to the exponent; otherwise keep bits 46:23.
  - Guard = next lower bit. Sticky = OR of all remaining lower bits.
- **ROUND:**
  - Nearest-even: increment if guard & (sticky | lsb).
  - Toward +inf: increment if (guard|sticky) & positive.
  - Toward -inf: increment if (guard|sticky) & negative.
  - Toward zero: never increment.
  - Mantissa carry-out shifts right by one and adds 1 to the exponent.
  - `ine_o` = guard|sticky.
- **Overflow (final exponent ≥ 255):** `overflow_o`=1, `ine_o`=1.
  - Result is ±inf (`inf_o`=1) for nearest-even, and for the directed mode rounding away from zero.
  - Otherwise result is ±0x7F7FFFFF (max finite).
- **Underflow (final exponent ≤ 0, finite nonzero product):** result is signed zero; `underflow_o`=1, `ine_o`=1, `zero_o`=1.
- **Special cases:** these bypass the arithmetic but keep the same latency.
  - Any sNaN input: `snan_o`=1.
  - Any qNaN input: `qnan_o`=1.
  - inf × 0 (either order): `qnan_o`=1.
  - All three NaN cases above output 0x7FC00000.
  - inf × finite nonzero (or inf × inf) gives signed inf with `inf_o`=1.
  - 0 × finite gives signed zero with `zero_o`=1.
- **Flags:** `inf_o` and `zero_o` reflect the final result. `output_o` and all flags update only at ROUND→DONE and hold until the next completion.

## Timing
- Reset values: state IDLE, `ready_o`=0, `output_o`=0, all flags 0.
- Latency is fixed for all operands. With `start_i` sampled at edge E0, `ready_o` is high from E26 to E27.
- The issuing side may assert `start_i` in the cycle `ready_o` is high. That start is accepted, giving back-to-back throughput of one result per 26 cycles.
- Reset asserted mid-operation aborts immediately to IDLE with reset values. No `ready_o` pulse is produced for the aborted request.
- Input ports are ignored outside the acceptance cycle; operands may change freely while busy.

## Test plan
- **Basic multiply and latency:** 0x3F800000 × 0x3F800000, rmode 0 → `output_o`=0x3F800000, all flags 0, `ready_o` exactly 26 edges after the start edge.
- **Sign and normalization:** 0x40400000 × 0xC0200000 (3 × -2.5) → 0xC0F00000, `ine_o`=0. Then issue a start in the DONE cycle and check the second result arrives 26 cycles later.
- **Rounding modes:** 0x3F800001 × 0x3F800001 → rmode 0: 0x3F800002 with `ine_o`=1; rmode 2: 0x3F800003; rmode 1: 0x3F800002.
- **Overflow:** 0x7F000000 × 0x7F000000 → rmode 0: 0x7F800000 with `overflow_o`, `inf_o`, `ine_o` set; rmode 1: 0x7F7FFFFF with `overflow_o`=1, `inf_o`=0.
- **Special operands:** 0x7F800000 × 0x00000000 → 0x7FC00000 with `qnan_o`=1. Then 0x7F800001 × 0x3F800000 → 0x7FC00000 with `snan_o`=1. Then 0x00800000 × 0x3F000000 → 0x00000000 with `underflow_o`, `zero_o`, `ine_o` set.
- **Busy and reset:** pulse `start_i` with new operands during MUL → ignored, first result unchanged. Assert `rst` at MUL cycle 10 → outputs 0, no `ready_o`. A fresh start after reset completes normally.
